// File: rtl/rx_fifo.sv
// Receive FIFO behind the UART Rx shifter: captures bytes on the done strobe
// and gives the bus side registered pops, level/status, a sticky overrun and a threshold IRQ.
module rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_Pclk,
  input  logic          i_Reset,
  input  logic [7:0]    i_Rx_Data,
  input  logic          i_Rx_Done,
  input  logic          i_Rd_En,
  input  logic          i_Ovr_Clr,
  input  logic [AW:0]   i_Thresh,
  output logic [7:0]    o_Rd_Data,
  output logic          o_Rd_Valid,
  output logic          o_Empty,
  output logic          o_Full,
  output logic [AW:0]   o_Level,
  output logic          o_Overrun,
  output logic          o_Irq
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_p0;
  logic [AW:0]   level_nxt;
  logic          wr_en;
  logic          rd_acc;
  logic          drop;
  logic [7:0]    rd_data_p1;
  logic          vld_p1;
  logic          ovr_p0;
  logic          irq_p0;

  // Threshold of zero disables the interrupt; thresholds above DEPTH never match.
  function automatic logic thresh_hit(input logic [AW:0] lvl, input logic [AW:0] th);
    return (th != '0) && (lvl >= th);
  endfunction

  assign o_Level    = level_p0;
  assign o_Empty    = (level_p0 == '0);
  assign o_Full     = (level_p0 == FULL_LVL);
  assign o_Rd_Data  = rd_data_p1;
  assign o_Rd_Valid = vld_p1;
  assign o_Overrun  = ovr_p0;
  assign o_Irq      = irq_p0;

  // A pop frees a slot this cycle, so a full FIFO can still accept a byte alongside it.
  always_comb begin
    rd_acc    = i_Rd_En && !o_Empty;
    wr_en     = i_Rx_Done && (!o_Full || rd_acc);
    drop      = i_Rx_Done && o_Full && !rd_acc;
    level_nxt = level_p0;
    if (wr_en && !rd_acc)
      level_nxt = level_p0 + ONE;
    else if (rd_acc && !wr_en)
      level_nxt = level_p0 - ONE;
  end

  // Storage: no reset; the read below sees the pre-write contents.
  always_ff @(posedge i_Pclk) begin
    if (wr_en && !i_Reset)
      mem[wr_ptr] <= i_Rx_Data;
  end

  // Stage p0 -> p1: pointers, level, status flags and the registered read port.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_p0   <= '0;
      rd_data_p1 <= 8'h00;
      vld_p1     <= 1'b0;
      ovr_p0     <= 1'b0;
      irq_p0     <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + 1'b1;
        rd_data_p1 <= mem[rd_ptr];
      end
      vld_p1   <= rd_acc;
      level_p0 <= level_nxt;
      if (drop)
        ovr_p0 <= 1'b1;
      else if (i_Ovr_Clr)
        ovr_p0 <= 1'b0;
      irq_p0 <= thresh_hit(level_nxt, i_Thresh);
    end
  end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive buffer directly downstream of the UART Rx shift register.
- Captures each received byte on the shifter's one-cycle done pulse and holds it in a circular FIFO for the bus/CPU side to read.
- Provides level, full/empty status, a sticky overrun flag and a threshold interrupt.
- Single clock domain (peripheral clock).

Parameters:
- DEPTH, 16, number of byte entries. Must be a power of two and at least 2.
- AW, 4, pointer width. Must equal log2(DEPTH).

Ports:
- i_Pclk  input  1  peripheral clock; all logic on its rising edge
- i_Reset  input  1  synchronous, active-high reset
- i_Rx_Data  input  8  received byte from the Rx shift register
- i_Rx_Done  input  1  one-cycle strobe; i_Rx_Data is valid in the same cycle
- i_Rd_En  input  1  read request (pop) from the bus side
- i_Ovr_Clr  input  1  clears o_Overrun
- i_Thresh  input  AW+1  interrupt threshold level; 0 disables o_Irq
- o_Rd_Data  output  8  popped byte, registered
- o_Rd_Valid  output  1  high for one cycle when o_Rd_Data carries a freshly popped byte
- o_Empty  output  1  level == 0
- o_Full  output  1  level == DEPTH
- o_Level  output  AW+1  number of stored bytes, 0..DEPTH
- o_Overrun  output  1  sticky: a received byte was dropped because the FIFO was full
- o_Irq  output  1  registered level-threshold interrupt

Behaviour:
- Reset values (i_Reset high at a clock edge):
  - write pointer, read pointer and o_Level = 0
  - o_Rd_Data = 8'h00, o_Rd_Valid = 0, o_Overrun = 0, o_Irq = 0
  - o_Empty = 1, o_Full = 0
  - Reset wins over every other input in the same cycle. Storage contents need no reset.
- Storage:
  - DEPTH x 8 array.
  - wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH (natural overflow).
  - Level is tracked by a separate AW+1-bit counter, not derived from the pointers.
- Write:
  - Occurs when i_Rx_Done=1 and (o_Full=0, or a pop is accepted in the same cycle).
  - Stores i_Rx_Data at wr_ptr, then increments wr_ptr.
- Pop:
  - Accepted when i_Rd_En=1 and o_Empty=0.
  - Next cycle: o_Rd_Data = mem[rd_ptr] and o_Rd_Valid = 1. Latency is exactly 1 clock. rd_ptr increments.
  - i_Rd_En while empty is ignored: no valid, pointers unchanged, o_Rd_Data holds.
  - o_Rd_Valid is 0 in every cycle not following an accepted pop.
  - o_Rd_Data holds its last value between pops.
- Level update:
  - write only: +1
  - pop only: -1
  - both in the same cycle: unchanged
  - neither: unchanged
- o_Empty and o_Full are combinational decodes of the registered level.
- Simultaneous events:
  - Full, with i_Rx_Done and an accepted pop: both occur, level stays DEPTH, no overrun.
  - Empty, with i_Rx_Done and i_Rd_En: the write occurs and the pop is ignored; level becomes 1. A same-cycle write never bypasses to the read port.
- Overrun:
  - i_Rx_Done=1 while full with no accepted pop: the byte is dropped, storage and pointers are unchanged, and o_Overrun is set next cycle.
  - o_Overrun stays set until i_Ovr_Clr=1.
  - If the clear and a new drop occur in the same cycle, set wins.
- Interrupt:
  - o_Irq is registered: next-state o_Irq = (i_Thresh != 0) && (next level >= i_Thresh).
  - It therefore asserts in the same cycle o_Level reaches the threshold.
  - i_Thresh greater than DEPTH means o_Irq never asserts.
- No state machine beyond the pointer/level counters; all outputs are registered except o_Empty and o_Full.

Test Plan:
- Reset then idle:
  - Required: o_Empty=1, o_Full=0, o_Level=0, o_Rd_Valid=0, o_Overrun=0, o_Irq=0.
  - i_Rd_En pulsed while empty -> o_Rd_Valid stays 0.
- Write 8'hA5 then 8'h3C via i_Rx_Done pulses -> o_Level=2.
  - Two i_Rd_En pulses -> o_Rd_Valid one cycle after each, with o_Rd_Data=A5 then 3C.
  - o_Empty=1 after the second pop.
- Fill 16 bytes 0..15 -> o_Full=1.
  - A 17th write of 8'hFF -> o_Overrun=1 next cycle, o_Level stays 16.
  - Drain -> bytes read out are 0..15 in order; 8'hFF is absent.
  - i_Ovr_Clr=1 -> o_Overrun=0.
  - Clear and a drop in the same cycle -> o_Overrun stays 1.
- Full FIFO with i_Rx_Done and i_Rd_En in the same cycle:
  - No overrun, o_Level=16, popped byte is the oldest entry.
  - Empty FIFO with both asserted -> o_Level=1, no o_Rd_Valid.
- Wrap-around: 40 interleaved write/read pairs with incrementing data -> data read out in order, with no loss or duplication across the pointer wrap.
- Threshold and mid-operation reset:
  - i_Thresh=4: o_Irq=1 exactly when o_Level becomes 4, and 0 when it drops to 3.
  - i_Thresh=0 -> o_Irq never asserts.
  - i_Reset asserted with level 9 and overrun set -> all reset values the next cycle.
